// File: rtl/recon_mul_add.sv
// Sequential shift-add multiply-accumulate: dividend = quotient * divisor + remainder.
// Retires one multiplier bit per clock, so every operation takes exactly WIDTH cycles.
module recon_mul_add #(
   parameter int WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     quotient,
   input  logic [WIDTH-1:0]     divisor,
   input  logic [WIDTH-1:0]     remainder,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   dividend,
   output logic                 rem_err
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   acc_next;
   logic [WIDTH-1:0]     mplier;
   logic [CNT_W-1:0]     cnt;
   logic                 err_q;

   function automatic logic [2*WIDTH-1:0] add_step(input logic [2*WIDTH-1:0] a,
                                                   input logic [2*WIDTH-1:0] m,
                                                   input logic            sel);
      return sel ? a + m : a;
   endfunction

   // The final iteration's add must reach dividend on the same edge, so it is computed combinationally.
   assign acc_next = add_step(acc, mcand, mplier[0]);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         rem_err  <= 1'b0;
         dividend <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         err_q    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  acc    <= {{WIDTH{1'b0}}, remainder};
                  mcand  <= {{WIDTH{1'b0}}, divisor};
                  mplier <= quotient;
                  cnt    <= '0;
                  err_q  <= (remainder >= divisor);
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNT_W'(1);
               // No early exit: latency stays fixed regardless of multiplier value.
               if (cnt == LAST) begin
                  dividend <= acc_next;
                  rem_err  <= err_q;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_recon_mul_add.sv
// Directed bench for recon_mul_add: table of single operations plus hand-written
// sequences for start-while-busy, back-to-back start and mid-run reset.
module tb_recon_mul_add;

   localparam int W = 64;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [W-1:0]   quotient;
   logic [W-1:0]   divisor;
   logic [W-1:0]   remainder;
   logic           busy;
   logic           done;
   logic [2*W-1:0] dividend;
   logic           rem_err;

   int pass_cnt = 0;
   int total_cnt = 0;

   recon_mul_add #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .quotient  (quotient),
      .divisor   (divisor),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .dividend  (dividend),
      .rem_err   (rem_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] d;
      logic [W-1:0] r;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
      logic         exp_err;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Called at a negedge; returns at the negedge where done is seen (or budget expires).
   task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                         output logic [2*W-1:0] res, output logic err,
                         output int bcnt, output int lat);
      quotient  = q;
      divisor   = d;
      remainder = r;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bcnt = 0;
      lat  = 0;
      while (!done && lat < 200) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      res = dividend;
      err = rem_err;
   endtask

   initial begin
      logic [2*W-1:0] res;
      logic           err;
      int             bcnt;
      int             lat;
      int             gap;
      int             seen_done;

      vecs[0] = '{64'd17, 64'd5, 64'd2, 64'd0, 64'd87, 1'b0};
      vecs[1] = '{64'd2, 64'd20, 64'd19, 64'd0, 64'd59, 1'b0};
      vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
                  64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[4] = '{64'd5, 64'd0, 64'd3, 64'd0, 64'd3, 1'b1};
      vecs[5] = '{64'd4, 64'd5, 64'd5, 64'd0, 64'd25, 1'b1};
      vecs[6] = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1};
      vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0,
                  64'h4000_0000_0000_0000, 64'd0, 1'b0};

      reset     = 1'b0;
      start     = 1'b1;
      quotient  = 64'd9;
      divisor   = 64'd9;
      remainder = 64'd9;
      repeat (3) @(negedge clk);
      check("reset_busy", {127'd0, busy}, 128'd0);
      check("reset_done", {127'd0, done}, 128'd0);
      check("reset_dividend", dividend, 128'd0);
      check("reset_rem_err", {127'd0, rem_err}, 128'd0);

      // First start coincides with the first edge that sees reset released.
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].q, vecs[i].d, vecs[i].r, res, err, bcnt, lat);
         check($sformatf("v%0d_latency", i), 128'(lat), 128'd64);
         check($sformatf("v%0d_busy_cycles", i), 128'(bcnt), 128'd64);
         check($sformatf("v%0d_dividend", i), res, {vecs[i].exp_hi, vecs[i].exp_lo});
         check($sformatf("v%0d_rem_err", i), {127'd0, err}, {127'd0, vecs[i].exp_err});
         @(negedge clk);
         check($sformatf("v%0d_done_pulse", i), {127'd0, done}, 128'd0);
      end

      // Start re-asserted mid-run with new operands is ignored; held high, it is taken right after done.
      quotient  = 64'd17;
      divisor   = 64'd5;
      remainder = 64'd2;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      quotient  = 64'd1;
      divisor   = 64'd1;
      remainder = 64'd0;
      start     = 1'b1;
      lat = 0;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("ignore_first_done_seen", {127'd0, done}, 128'd1);
      check("ignore_dividend", dividend, 128'd87);
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy_restart", {127'd0, busy}, 128'd1);
      check("b2b_hold_old", dividend, 128'd87);
      gap = 1;
      while (!done && gap < 200) begin
         @(negedge clk);
         gap++;
      end
      check("b2b_gap", 128'(gap), 128'd65);
      check("b2b_dividend", dividend, 128'd1);
      check("b2b_rem_err", {127'd0, rem_err}, 128'd0);
      @(negedge clk);
      check("b2b_idle_after", {127'd0, busy}, 128'd0);

      // Reset mid-run aborts the operation without a done pulse.
      quotient  = 64'd17;
      divisor   = 64'd0;
      remainder = 64'd2;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b0;
      start = 1'b1;
      @(negedge clk);
      check("abort_busy", {127'd0, busy}, 128'd0);
      check("abort_done", {127'd0, done}, 128'd0);
      check("abort_dividend", dividend, 128'd0);
      check("abort_rem_err", {127'd0, rem_err}, 128'd0);
      @(negedge clk);
      start = 1'b0;
      reset = 1'b1;
      seen_done = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (done || busy) seen_done++;
      end
      check("abort_no_done", 128'(seen_done), 128'd0);
      run_op(64'd3, 64'd7, 64'd1, res, err, bcnt, lat);
      check("post_reset_latency", 128'(lat), 128'd64);
      check("post_reset_dividend", res, 128'd22);
      check("post_reset_rem_err", {127'd0, err}, 128'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/recon_mul_add.md
# recon_mul_add

Sequential shift-add multiply-accumulate unit that computes the inverse of the divider: given Quotient, Divisor and Remainder, it reconstructs Dividend = Quotient × Divisor + Remainder at full double width. It is a multi-cycle block, one multiplier bit per clock, with a start/busy/done handshake. It sits beside the divider as its check/inverse path and as a general unsigned multiplier when Remainder = 0.

## Interface
- WIDTH, 64, operand width in bits; the result is 2×WIDTH bits.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request; sampled only when the FSM is IDLE.
- quotient  input  WIDTH  multiplier operand (unsigned).
- divisor  input  WIDTH  multiplicand operand (unsigned).
- remainder  input  WIDTH  addend (unsigned).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse: dividend and rem_err are valid.
- dividend  output  2×WIDTH  registered result Q×D+R; held until the next completion.
- rem_err  output  1  registered with done; 1 if the latched remainder ≥ divisor, including divisor = 0.

## Operation
- FSM states: IDLE, RUN.
- IDLE, start=1: the block latches the operands.
  - acc ← zero-extended remainder (2×WIDTH).
  - mcand ← zero-extended divisor (2×WIDTH).
  - mplier ← quotient.
  - cnt ← 0; err_q ← (remainder ≥ divisor).
  - Next state RUN, busy ← 1.
- IDLE, start=0: no change; outputs hold.
- RUN, each edge:
  - if mplier[0], acc ← acc + mcand;
  - then mcand ← mcand << 1, mplier ← mplier >> 1, cnt ← cnt + 1.
- RUN, edge performing iteration cnt = WIDTH−1:
  - dividend ← final acc (including that iteration's add).
  - rem_err ← err_q; done ← 1; busy ← 0; next state IDLE.
- Arithmetic: all unsigned, mod 2^(2×WIDTH). No overflow is possible, since the maximum is (2^W−1)² + 2^W−1 < 2^(2W).
- Fixed latency: no early termination for zero or short multipliers.
- The remainder ≥ divisor case is flagged only; the result is still computed exactly.
- start while busy (RUN): ignored, operands not re-latched.
- start high in the cycle done is high: accepted (FSM already IDLE). The next run begins and dividend holds the old result until that run's completion.
- Input changes during RUN have no effect; the operands are latched.

## Timing
- Start sampled at edge E0 → iterations on edges E1..E_WIDTH.
- dividend, rem_err and done update at E_WIDTH, so latency = WIDTH cycles from the sampling edge.
- busy: rises at E0, falls at E_WIDTH, i.e. high for exactly WIDTH cycles.
- done: rises at E_WIDTH, falls at E_WIDTH+1. It is never high for two consecutive cycles.
- Back-to-back throughput: one result per WIDTH+1 cycles when start is held high continuously.
- Reset (reset=0 at any edge, including mid-RUN):
  - state ← IDLE; busy, done, rem_err ← 0; dividend ← 0.
  - Internal acc, mcand, mplier, cnt, err_q ← 0.
  - An in-flight operation is aborted with no done pulse.
  - start is ignored on any edge where reset=0.
- First start is accepted on the first edge with reset=1.

## Test plan
- Q=17, D=5, R=2, start one cycle → after 64 edges: dividend=87, rem_err=0, done high exactly one cycle, busy high 64 cycles.
- Q=2, D=20, R=19 → dividend=59, rem_err=0; then Q=0x7FFF_FFFF_FFFF_FFFF, D=2, R=1 → dividend hi=0, lo=0xFFFF_FFFF_FFFF_FFFF.
- Q=D=0xFFFF_FFFF_FFFF_FFFF, R=0xFFFF_FFFF_FFFF_FFFE → dividend hi=0xFFFF_FFFF_FFFF_FFFE, lo=0xFFFF_FFFF_FFFF_FFFF, rem_err=0.
- Q=5, D=0, R=3 → dividend=3, rem_err=1; Q=4, D=5, R=5 → dividend=25, rem_err=1.
- Start Q=17, D=5, R=2; pulse start again at cycle 10 with Q=1, D=1, R=0 → ignored, result 87. Keep start high through done → second op (Q=1, D=1) completes 65 cycles after the first done with dividend=1.
- Start an operation, assert reset=0 at iteration 10 → busy/done/dividend/rem_err=0 and no done pulse. Release reset, start Q=3, D=7, R=1 → dividend=22 after 64 edges.
